// File: rtl/dmem_pkg.sv
// Shared sizing constants and dump FSM state type for the LEGv8 data-memory dump endpoint.
package dmem_pkg;

  localparam int DMEM_N     = 64;
  localparam int DMEM_DEPTH = 64;
  localparam int WIDX_W     = 6;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} dump_state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x N word storage: synchronous write, combinational core and dump reads, synchronous clear.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int N     = DMEM_N,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      addr,
  input  logic [N-1:0]      wdata,
  input  logic              we,
  output logic [N-1:0]      rdata,
  input  logic [WIDX_W-1:0] dump_idx,
  output logic [N-1:0]      dump_rdata
);

  localparam logic [N-1:0] ADDR_LIMIT = N'(DEPTH * 8);

  logic [N-1:0]      mem_q [DEPTH];
  logic [N-1:0]      mem_d [DEPTH];
  logic [WIDX_W-1:0] word_idx;
  logic              in_range;

  // Byte address -> word index; the low three bits select a byte and are ignored.
  assign word_idx = addr[WIDX_W+2:3];
  assign in_range = (addr < ADDR_LIMIT);

  always_comb begin
    mem_d = mem_q;
    if (we && in_range) begin
      mem_d[word_idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata      = in_range ? mem_q[word_idx] : '0;
  assign dump_rdata = mem_q[dump_idx];

endmodule

// File: rtl/dmem_dump_unit.sv
// Data memory for the LEGv8 core with a valid/ready dump stream triggered by a rising dump.
// Optional feature: DMEM_DUMP_SKIP_ZERO_EN suppresses zero-valued words from the stream.
module dmem_dump_unit
  import dmem_pkg::*;
#(
  parameter int N     = DMEM_N,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N-1:0]      DM_addr,
  input  logic [N-1:0]      DM_writeData,
  input  logic              DM_writeEnable,
  output logic [N-1:0]      DM_readData,
  input  logic              dump,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [WIDX_W-1:0] dump_addr,
  output logic [N-1:0]      dump_data,
  output logic              dump_done
);

  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(DEPTH - 1);

  dump_state_t       state_q, state_d;
  logic              dump_prev_q, dump_prev_d;
  logic              valid_q, valid_d;
  logic [WIDX_W-1:0] addr_q, addr_d;
  logic [N-1:0]      data_q, data_d;

  logic              dump_rise;
  logic              load_en;
  logic [WIDX_W-1:0] load_idx;
  logic [N-1:0]      load_word;

  dmem_array #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_array (
    .clk        (CLOCK_50),
    .reset      (reset),
    .addr       (DM_addr),
    .wdata      (DM_writeData),
    .we         (DM_writeEnable),
    .rdata      (DM_readData),
    .dump_idx   (load_idx),
    .dump_rdata (load_word)
  );

  assign dump_rise = dump && !dump_prev_q;

  // addr_q doubles as the scan pointer: it is the last index loaded or examined.
  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    load_idx = addr_q;
    unique case (state_q)
      IDLE: begin
        if (dump_rise) begin
          state_d  = SCAN;
          load_en  = 1'b1;
          load_idx = '0;
        end
      end
      SCAN: begin
        if (valid_q && !dump_ready) begin
          state_d = SCAN;
        end else if (addr_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          load_en  = 1'b1;
          load_idx = addr_q + WIDX_W'(1);
        end
      end
      DONE: begin
        if (!dump) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The snapshot reads the array before this edge's core write lands.
  always_comb begin
    dump_prev_d = dump;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    if (state_d == DONE) begin
      valid_d = 1'b0;
    end
    if (load_en) begin
      addr_d = load_idx;
      data_d = load_word;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
      valid_d = (load_word != '0);
`else
      valid_d = 1'b1;
`endif
    end
  end

  // Previous-dump resets high so a dump held through reset cannot self-trigger.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      dump_prev_q <= 1'b1;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      dump_prev_q <= dump_prev_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_done  = (state_q == DONE);

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Self-checking bench for dmem_dump_unit against a word-array reference model.
module tb_dmem_dump_unit;

  localparam int DEPTH = 64;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_writeEnable;
  logic [63:0] DM_readData;
  logic        dump;
  logic        dump_valid;
  logic        dump_ready;
  logic [5:0]  dump_addr;
  logic [63:0] dump_data;
  logic        dump_done;

  int total = 0;
  int bad   = 0;
  logic [63:0] ref_mem [DEPTH];

  dmem_dump_unit #(.N(64), .DEPTH(DEPTH)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readData    (DM_readData),
    .dump           (dump),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_addr      (dump_addr),
    .dump_data      (dump_data),
    .dump_done      (dump_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    DM_addr        = a;
    DM_writeData   = d;
    DM_writeEnable = 1'b1;
    step();
    DM_writeEnable = 1'b0;
    if (a < 64'(DEPTH * 8)) ref_mem[a[8:3]] = d;
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] a, input logic [63:0] exp);
    DM_addr = a;
    #1;
    chk(tag, DM_readData, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // mode 0: ready always high; 1: stall 3 cycles on word 5; 2: random ready + write to word 7 mid-stream.
  task automatic run_dump(input int mode);
    int          exp_a[$];
    logic [63:0] exp_d[$];
    int          k, cyc, stalls, stall_left;
    bit          wrote, r;
    for (int i = 0; i < DEPTH; i++) begin
      if (!SKIP || ref_mem[i] != 64'd0) begin
        exp_a.push_back(i);
        exp_d.push_back(ref_mem[i]);
      end
    end
    dump_ready = 1'b1;
    dump = 1'b1;
    step();
    k = 0; cyc = 0; stalls = 0; stall_left = 3; wrote = 0;
    while (!dump_done && cyc < 400) begin
      r = 1'b1;
      if (mode == 1 && dump_valid && dump_addr == 6'd5 && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end
      if (mode == 2) r = ($urandom_range(0, 3) != 0);
      dump_ready = r;
      if (dump_valid) begin
        if (k < exp_a.size()) begin
          chk($sformatf("beat%0d_addr", k), 64'(dump_addr), 64'(exp_a[k]));
          chk($sformatf("beat%0d_data", k), dump_data, exp_d[k]);
        end else begin
          chk("extra_beat_valid", 64'(dump_valid), 64'd0);
        end
        if (r) k++;
        else   stalls++;
        if (mode == 2 && dump_addr == 6'd7 && !wrote) begin
          DM_addr        = 64'h38;
          DM_writeData   = 64'hAA;
          DM_writeEnable = 1'b1;
          wrote          = 1'b1;
          ref_mem[7]     = 64'hAA;
        end
      end
      step();
      DM_writeEnable = 1'b0;
      cyc++;
    end
    chk("dump_done_reached", 64'(dump_done), 64'd1);
    chk("beat_count", 64'(k), 64'(exp_a.size()));
    chk("done_cycle", 64'(cyc), 64'(DEPTH + stalls));
    dump_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("held_valid", 64'(dump_valid), 64'd0);
      chk("held_done", 64'(dump_done), 64'd1);
    end
    dump = 1'b0;
    step();
    chk("done_clear", 64'(dump_done), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    dump           = 1'b0;
    dump_ready     = 1'b1;
    DM_addr        = '0;
    DM_writeData   = '0;
    DM_writeEnable = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(dump_valid), 64'd0);
    chk("rst_done",  64'(dump_done),  64'd0);
    chk("rst_addr",  64'(dump_addr),  64'd0);
    chk("rst_data",  dump_data,       64'd0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rd_chk("rst_read0", 64'h0, 64'd0);

    // Store/load and byte-offset aliasing
    wr(64'h10, 64'hDEADBEEF);
    rd_chk("load_0x10", 64'h10, 64'hDEADBEEF);
    rd_chk("load_0x14", 64'h14, 64'hDEADBEEF);

    // Out-of-range writes and reads
    wr(64'h200, 64'h1234_5678_9ABC_DEF0);
    wr(64'h200 + 64'($urandom_range(0, 4095)), {$urandom, $urandom});
    rd_chk("oor_read", 64'h200, 64'd0);
    for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("oor_word%0d", i), 64'(i * 8), ref_mem[i]);

    // Directed full dump and backpressure over a sparse memory
    do_reset();
    wr(64'h0, 64'd1);
    wr(64'h10, 64'd2);
    wr(64'h1F8, 64'd3);
    run_dump(0);
    run_dump(1);

    // Randomised memory with random ready and a snapshot write to word 7
    for (int i = 0; i < DEPTH; i++) begin
      logic [63:0] v;
      v = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      if (i == 7) v = v | 64'h100;
      wr(64'(i * 8) + 64'($urandom_range(0, 7)), v);
    end
    run_dump(2);
    rd_chk("snapshot_read7", 64'h38, 64'hAA);

    // Reset mid-dump with dump held high
    for (int i = 0; i < DEPTH; i++) wr(64'(i * 8), {$urandom, $urandom} | 64'd1);
    dump_ready = 1'b1;
    dump = 1'b1;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("pre_reset_addr", 64'(dump_addr), 64'd10);
    chk("pre_reset_data", dump_data, ref_mem[10]);
    do_reset();
    chk("mid_rst_valid", 64'(dump_valid), 64'd0);
    chk("mid_rst_done",  64'(dump_done),  64'd0);
    chk("mid_rst_addr",  64'(dump_addr),  64'd0);
    chk("mid_rst_data",  dump_data,       64'd0);
    for (int i = 0; i < DEPTH; i++) rd_chk($sformatf("mid_rst_word%0d", i), 64'(i * 8), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_restart_valid", 64'(dump_valid), 64'd0);
      chk("no_restart_done",  64'(dump_done),  64'd0);
    end
    dump = 1'b0;
    step();
    run_dump(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_dump_unit.md
# dmem_dump_unit

Data-memory endpoint for the pipelined LEGv8 core: accepts the processor's `DM_*` write port, serves `DM_readData` reads, and, when `dump` rises, streams the memory contents out on a valid/ready port. The bench or a future UART/JTAG drain uses this stream to check results. It sits opposite the core's memory stage and replaces the bare data memory behind `processor_arm`.

## Interface
- `N`, default 64, data and address width.
- `DEPTH`, default 64, number of N-bit words.
- `CLOCK_50`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `DM_addr`  in  N  byte address from the core. The word index is `DM_addr[8:3]`; bits `[2:0]` are ignored.
- `DM_writeData`  in  N  store data.
- `DM_writeEnable`  in  1  store strobe.
- `DM_readData`  out  N  combinational read of the word at `DM_addr`.
- `dump`  in  1  dump request; level input, acted on at its rising edge.
- `dump_valid`  out  1  a stream word is presented.
- `dump_ready`  in  1  the sink accepts the presented word.
- `dump_addr`  out  6  word index of the presented word.
- `dump_data`  out  N  value of the presented word.
- `dump_done`  out  1  high while in DONE.

## Operation
- **Storage.** DEPTH x N array. On reset, every word is cleared to 0.
- **Writes.** A word is written at the clock edge when `DM_writeEnable=1` and `DM_addr < DEPTH*8`.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 0.
- **Dump FSM:** IDLE -> SCAN -> DONE.
  - IDLE -> SCAN when `dump=1` and the registered previous `dump` value is 0. On this edge the pointer is set to 0 and word 0 is loaded into the output register.
  - In SCAN, a handshake (`dump_valid & dump_ready` at an edge) advances the pointer and loads the next word on that same edge.
  - SCAN -> DONE on the handshake of word DEPTH-1.
  - DONE -> IDLE when `dump=0`. Holding `dump` high never restarts a dump; it must fall and rise again.
- **Output register.** `dump_data` and `dump_addr` are a snapshot taken at load time. They are held stable while `dump_valid & ~dump_ready`.
- **Write collision.** A core write to the word being loaded on the same edge: the snapshot gets the old value (read-before-write). Writes during SCAN are otherwise unrestricted.
- **`dump_valid`** is high in SCAN whenever a word is loaded and not yet accepted.
- **Reset mid-dump.** State returns to IDLE, outputs go to their reset values and memory is cleared on the next edge. The previous-`dump` register resets to 1, so a `dump` held high through reset does not start a dump.

## Timing
- **Reset values:** `dump_valid=0`, `dump_done=0`, `dump_addr=0`, `dump_data=0`. `DM_readData` follows the array, which is 0 after reset.
- **Read latency:** 0 cycles (combinational). A value written at edge t is visible on `DM_readData` after edge t.
- **Dump rising edge sampled at edge t:**
  - `dump_valid=1` with word 0 after edge t.
  - With `dump_ready` held 1, beat k is accepted at edge t+1+k.
  - The last beat is accepted at edge t+DEPTH.
  - `dump_done=1` after edge t+DEPTH.
- **Throughput:** one word per cycle; there are no bubbles between beats when `dump_ready=1`.
- **Pointer width:** 6 bits; it never wraps, because DONE is entered instead.

## Configuration
- **`DMEM_DUMP_SKIP_ZERO_EN` defined:**
  - A word whose value is 0 at load time is not presented. The pointer advances one index per cycle while no word is pending.
  - SCAN -> DONE after index DEPTH-1 has been examined or accepted.
  - If all words are 0, `dump_valid` stays 0 and `dump_done` rises DEPTH cycles after the dump edge.
- **Undefined:** all DEPTH words are streamed, including zero words.

## Structure
- **`dmem_pkg`** holds `N`, `DEPTH`, the word-index width `WIDX_W=6` and `typedef enum logic [1:0] {IDLE, SCAN, DONE} dump_state_t`.
- **Sub-module `dmem_array`** holds the storage: one synchronous write port, one combinational core read port, one combinational dump read port, and the synchronous clear.
- **Top level** holds the FSM, edge detector, pointer and output register.

## Test plan
- **Store/load:** reset; write 64'hDEADBEEF at `DM_addr=0x10` -> `DM_readData` at 0x10 is 64'hDEADBEEF the next cycle; `DM_addr=0x14` reads the same word.
- **Full dump:** words 0, 2, 63 = 1, 2, 3; `dump_ready=1`; `dump` rises -> 64 beats, `dump_addr` 0..63 on consecutive cycles, data 1,0,2,0..0,3; `dump_done` one cycle after the last beat.
- **Backpressure:** drop `dump_ready` for 3 cycles while word 5 is presented -> `dump_addr=5` and its data are held unchanged; the stream then resumes at 6 with no skip or duplicate.
- **Snapshot:** write 0xAA to word 7 the cycle after word 7 is loaded -> the stream shows the old value of word 7; `DM_readData` at 0x38 shows 0xAA.
- **Out of range:** write at `DM_addr=0x200` -> no word changes; read at 0x200 returns 0.
- **Reset mid-dump:** assert `reset` at beat 10 with `dump` held high -> the next cycle has `dump_valid=0`, `dump_done=0` and all words 0; no new dump starts until `dump` toggles 0->1.
- **Skip-zero (with `DMEM_DUMP_SKIP_ZERO_EN`):** same memory as the full-dump test -> exactly 3 beats with addr 0, 2, 63, then `dump_done`.
